div_issue_ctrl: RTL

//  EX-side controller for the multi-cycle divider (div). Accepts DIV/DIVU/REM/REMU

---
 rtl/div_issue_ctrl_pkg.sv | 24 ++
 rtl/div_issue_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared widths, funct3 codes and FSM encoding for the divider issue controller.
// Values mirror the core-wide defines so ex can wire div port-to-port.
package div_issue_ctrl_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int FUNCT3_WIDTH   = 3;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [FUNCT3_WIDTH-1:0] INST_DIV  = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] INST_DIVU = 3'b101;
  localparam logic [FUNCT3_WIDTH-1:0] INST_REM  = 3'b110;
  localparam logic [FUNCT3_WIDTH-1:0] INST_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_WB   = 3'b100
  } div_state_e;

  function automatic logic rd_is_x0(input logic [REG_ADDR_WIDTH-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-side issue controller for the multi-cycle divider: launches div, stalls the
// pipeline while it runs, and returns a one-cycle register write-back.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter bit WB_ZERO_SKIP = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  input  logic [FUNCT3_WIDTH-1:0]   req_op_i,
  input  logic [CPU_WIDTH-1:0]      req_dividend_i,
  input  logic [CPU_WIDTH-1:0]      req_divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_i,
  input  logic                      flush_i,
  output logic                      hold_o,
  output logic                      div_start_o,
  output logic [FUNCT3_WIDTH-1:0]   div_op_o,
  output logic [CPU_WIDTH-1:0]      div_dividend_o,
  output logic [CPU_WIDTH-1:0]      div_divisor_o,
  input  logic [CPU_WIDTH-1:0]      div_result_i,
  input  logic                      div_ready_i,
  input  logic                      div_busy_i,
  output logic                      wb_we_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [CPU_WIDTH-1:0]      wb_data_o
);

  div_state_e                state_q, state_d;
  logic                      issue_slot;
  logic                      accept;
  logic                      zero_skip;
  logic                      launch;
  logic                      capture;

  logic [FUNCT3_WIDTH-1:0]   op_p0;
  logic [CPU_WIDTH-1:0]      dividend_p0;
  logic [CPU_WIDTH-1:0]      divisor_p0;
  logic [REG_ADDR_WIDTH-1:0] rd_p0;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_p1;
  logic [CPU_WIDTH-1:0]      wb_data_p1;

  always_comb begin
    issue_slot = (state_q == ST_IDLE) || (state_q == ST_WB);
    accept     = req_valid_i & ~flush_i & ~div_busy_i & issue_slot;
    zero_skip  = WB_ZERO_SKIP & rd_is_x0(req_rd_i);
    launch     = accept & ~zero_skip;
    capture    = (state_q == ST_BUSY) & div_ready_i & ~flush_i;

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WB: state_d = launch ? ST_BUSY : ST_IDLE;
      ST_BUSY: begin
        if (flush_i)          state_d = ST_IDLE;
        else if (div_ready_i) state_d = ST_WB;
      end
      default:                state_d = ST_IDLE;
    endcase

    // start must drop in the ready cycle, otherwise div would relaunch from IDLE
    div_start_o    = (state_q == ST_BUSY) & ~div_ready_i;
    div_op_o       = op_p0;
    div_dividend_o = dividend_p0;
    div_divisor_o  = divisor_p0;

    hold_o = (state_q == ST_BUSY) | (req_valid_i & ~flush_i & ~accept) | launch;

    wb_we_o   = (state_q == ST_WB);
    wb_addr_o = wb_we_o ? wb_addr_p1 : '0;
    wb_data_o = wb_we_o ? wb_data_p1 : '0;
  end

  // p0: request latch; p1: write-back capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_p0       <= '0;
      dividend_p0 <= '0;
      divisor_p0  <= '0;
      rd_p0       <= '0;
      wb_addr_p1  <= '0;
      wb_data_p1  <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        op_p0       <= req_op_i;
        dividend_p0 <= req_dividend_i;
        divisor_p0  <= req_divisor_i;
        rd_p0       <= req_rd_i;
      end
      if (capture) begin
        wb_addr_p1 <= rd_p0;
        wb_data_p1 <= div_result_i;
      end
    end
  end

endmodule
